// File: rtl/tern_eq_table_gen.sv
// tern_eq_table_gen: streams the 81-entry three-valued equality table of two 2-bit {0,1,X} operands
module tern_eq_table_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  out_idx,
  output logic [1:0]  out_sym,
  output logic        out_last,
  output logic [80:0] table_val,
  output logic [80:0] table_known,
  output logic [6:0]  cnt_one,
  output logic [6:0]  cnt_zero,
  output logic [6:0]  cnt_x
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [1:0] i1, i2, i3, i4;
  logic [6:0] w1, w2, w3, w4, idx;
  logic [1:0] sym;
  logic u1, u2, d1, d2, acc, fin, c1, c2, c3;
  function automatic logic [1:0] nxt(input logic [1:0] d);
    return d == 2'd2 ? 2'd0 : d + 2'd1;
  endfunction
  always_comb begin
    w1 = {5'd0, i1};
    w2 = {5'd0, i2};
    w3 = {5'd0, i3};
    w4 = {5'd0, i4};
    idx = w1 + w2 + (w2 << 1) + w3 + (w3 << 3) + w4 + (w4 << 1) + (w4 << 3) + (w4 << 4);
    // digit 2 is X; pair (i1,i3) is the MSB pair, (i2,i4) the LSB pair
    u1 = i1 == 2'd2 || i3 == 2'd2;
    u2 = i2 == 2'd2 || i4 == 2'd2;
    d1 = !u1 && i1 != i3;
    d2 = !u2 && i2 != i4;
    sym = (d1 || d2) ? 2'b00 : (u1 || u2) ? 2'b10 : 2'b01;
    busy = state == RUN;
    out_valid = busy;
    out_idx = busy ? idx : 7'd0;
    out_sym = busy ? sym : 2'b00;
    out_last = busy && idx == 7'd80;
    acc = busy && out_ready;
    fin = acc && idx == 7'd80;
    c1 = i1 == 2'd2;
    c2 = c1 && i2 == 2'd2;
    c3 = c2 && i3 == 2'd2;
    state_nx = state == IDLE ? (start ? RUN : IDLE) : (fin ? IDLE : RUN);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      {i1, i2, i3, i4} <= '0;
      table_val <= '0;
      table_known <= '0;
      cnt_one <= '0;
      cnt_zero <= '0;
      cnt_x <= '0;
    end else begin
      done <= fin;
      if (state == IDLE && start) begin
        {i1, i2, i3, i4} <= '0;
        table_val <= '0;
        table_known <= '0;
        cnt_one <= '0;
        cnt_zero <= '0;
        cnt_x <= '0;
      end else if (acc) begin
        table_val[idx] <= sym == 2'b01;
        table_known[idx] <= sym != 2'b10;
        cnt_one <= cnt_one + (sym == 2'b01 ? 7'd1 : 7'd0);
        cnt_zero <= cnt_zero + (sym == 2'b00 ? 7'd1 : 7'd0);
        cnt_x <= cnt_x + (sym == 2'b10 ? 7'd1 : 7'd0);
        i1 <= nxt(i1);
        i2 <= c1 ? nxt(i2) : i2;
        i3 <= c2 ? nxt(i3) : i3;
        i4 <= c3 ? nxt(i4) : i4;
      end
    end
  end
endmodule

// File: tb/tb_tern_eq_table_gen.sv
// tb_tern_eq_table_gen: directed checks of the ternary equality table generator against a bench model
module tb_tern_eq_table_gen;
  logic clk = 1'b0, rst_n, start, out_ready;
  logic busy, done, out_valid, out_last;
  logic [6:0] out_idx, cnt_one, cnt_zero, cnt_x;
  logic [1:0] out_sym;
  logic [80:0] table_val, table_known;
  int n_chk = 0, n_err = 0;
  logic [80:0] ones_ref;
  tern_eq_table_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_sym(out_sym),
    .out_last(out_last), .table_val(table_val), .table_known(table_known),
    .cnt_one(cnt_one), .cnt_zero(cnt_zero), .cnt_x(cnt_x)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [80:0] got, input logic [80:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  function automatic logic [1:0] model(input int n);
    int a0, a1, b0, b1;
    bit dif, unk;
    a0 = n % 3;
    a1 = (n / 3) % 3;
    b0 = (n / 9) % 3;
    b1 = n / 27;
    unk = a0 == 2 || b0 == 2 || a1 == 2 || b1 == 2;
    dif = (a0 != 2 && b0 != 2 && a0 != b0) || (a1 != 2 && b1 != 2 && a1 != b1);
    return dif ? 2'b00 : unk ? 2'b10 : 2'b01;
  endfunction
  task automatic sweep(input int prob, input int start_at, input bit pre_started, input bit start_on_done);
    int e, cyc;
    logic [80:0] ev, ek;
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk("first_busy", {80'd0, busy}, 81'd1);
    chk("clr_val", table_val, 81'd0);
    chk("clr_known", table_known, 81'd0);
    chk("clr_cnt", {60'd0, cnt_one, cnt_zero, cnt_x}, 81'd0);
    e = 0;
    cyc = 0;
    ev = '0;
    ek = '0;
    while (e <= 80 && cyc < 2000) begin
      chk("valid", {80'd0, out_valid}, 81'd1);
      chk("idx", {74'd0, out_idx}, 81'(e));
      chk("sym", {79'd0, out_sym}, {79'd0, model(e)});
      chk("last", {80'd0, out_last}, {80'd0, e == 80});
      chk("no_done", {80'd0, done}, 81'd0);
      out_ready = $urandom_range(99) < prob;
      start = e == start_at;
      if (out_ready) begin
        ev[e] = model(e) == 2'b01;
        ek[e] = model(e) != 2'b10;
        e++;
      end
      cyc++;
      @(negedge clk);
    end
    chk("timeout", {80'd0, cyc < 2000}, 81'd1);
    if (prob == 100) chk("latency", 81'(cyc), 81'd81);
    chk("done", {80'd0, done}, 81'd1);
    chk("busy_off", {80'd0, busy}, 81'd0);
    chk("valid_off", {80'd0, out_valid}, 81'd0);
    chk("cnt_one", {74'd0, cnt_one}, 81'd4);
    chk("cnt_zero", {74'd0, cnt_zero}, 81'd32);
    chk("cnt_x", {74'd0, cnt_x}, 81'd45);
    chk("table_val", table_val, ev);
    chk("table_ones", table_val, ones_ref);
    chk("table_known", table_known, ek);
    start = start_on_done;
    out_ready = 1'b0;
  endtask
  initial begin
    ones_ref = '0;
    ones_ref[0] = 1'b1;
    ones_ref[10] = 1'b1;
    ones_ref[30] = 1'b1;
    ones_ref[40] = 1'b1;
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {80'd0, busy}, 81'd0);
    chk("rst_done", {80'd0, done}, 81'd0);
    chk("rst_valid", {80'd0, out_valid}, 81'd0);
    chk("rst_last", {80'd0, out_last}, 81'd0);
    chk("rst_idx", {74'd0, out_idx}, 81'd0);
    chk("rst_sym", {79'd0, out_sym}, 81'd0);
    chk("rst_tables", table_val | table_known, 81'd0);
    chk("rst_cnt", {60'd0, cnt_one, cnt_zero, cnt_x}, 81'd0);
    rst_n = 1'b1;
    sweep(100, -1, 1'b0, 1'b0);
    sweep(50, -1, 1'b0, 1'b0);
    sweep(100, 20, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    repeat (50) @(negedge clk);
    chk("pre_rst_idx", {74'd0, out_idx}, 81'd50);
    chk("pre_rst_ones", table_val, ones_ref);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {80'd0, busy}, 81'd0);
    chk("arst_valid", {80'd0, out_valid}, 81'd0);
    chk("arst_idx", {74'd0, out_idx}, 81'd0);
    chk("arst_sym", {79'd0, out_sym}, 81'd0);
    chk("arst_tables", table_val | table_known, 81'd0);
    chk("arst_cnt", {60'd0, cnt_one, cnt_zero, cnt_x}, 81'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_done", {80'd0, done}, 81'd0);
    end
    rst_n = 1'b1;
    out_ready = 1'b0;
    sweep(100, -1, 1'b0, 1'b0);
    sweep(100, -1, 1'b0, 1'b1);
    sweep(100, -1, 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/tern_eq_table_gen.md
# tern_eq_table_gen

Synthesizable generator for the three-valued equality truth table of two 2-bit operands whose bits range over {0, 1, X}. It walks all 81 operand combinations in order and streams one result symbol per combination over a valid/ready interface. It also accumulates the packed table and per-class counts in registers. It sits beside the 4-state comparison tests as a hardware golden source that a checker consumes, so that no simulator X semantics are involved.

## Interface
- No parameters. Table size 81 and symbol encoding are fixed.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  request a sweep; honoured only in IDLE
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the final beat is accepted
- out_valid  out  1  stream beat valid
- out_ready  in  1  consumer accepts the beat
- out_idx  out  7  entry index 0..80
- out_sym  out  2  result: 2'b00 = 0, 2'b01 = 1, 2'b10 = X (2'b11 is never emitted)
- out_last  out  1  high with idx 80
- table_val  out  81  bit idx is 1 iff the entry result is 1
- table_known  out  81  bit idx is 1 iff the entry result is 0 or 1 (not X)
- cnt_one, cnt_zero, cnt_x  out  7 each  result counts for the current or last sweep

## Operation
- Four base-3 digit counters i1, i2, i3, i4 (2 bits each). i1 is least significant: idx = i1 + 3*i2 + 9*i3 + 27*i4. The index is computed by addition, not division.
- Digit to ternary bit: 0 maps to 0, 1 maps to 1, 2 maps to X.
- Operands: A = {t(i1), t(i2)} and B = {t(i3), t(i4)}, with the MSB first.
- Per bit pair:
  - both known and different gives "differ";
  - either bit X gives "unknown";
  - otherwise "equal".
- Result:
  - 0 if any bit pair is "differ" (this has priority over X);
  - else X if any bit pair is "unknown";
  - else 1.
- FSM has two states:
  - IDLE: start=1 moves to RUN. All digits, table_val, table_known and the counts are cleared.
  - RUN: out_valid=1. On out_valid&out_ready:
    - write table_val[idx] and table_known[idx];
    - increment the matching count;
    - advance the digits, with carry from a digit at 2 back to 0 into the next digit.
  - When the beat with idx 80 is accepted, go to IDLE and pulse done.
- start in RUN is ignored. It does not restart or extend the sweep.
- Tables and counts hold their values in IDLE until the next start.
- Per-sweep invariants: cnt_one=4, cnt_zero=32, cnt_x=45 (sum 81).

## Timing
- Reset values: FSM IDLE; busy, done, out_valid, out_last = 0; out_idx=0; out_sym=2'b00; tables all 0; counts 0. rst_n asserted mid-sweep aborts immediately to these values with no done pulse.
- start is sampled at edge k. busy and out_valid are high from cycle k+1, with idx 0 presented.
- out_idx, out_sym and out_last are driven from registered state only. They are stable while out_valid=1 and out_ready=0.
- Throughput is one beat per cycle. With out_ready held high: beats occupy cycles k+1..k+81 and done=1 in cycle k+82, with busy=0 in that cycle.
- Table and count updates are visible the cycle after the accepting edge.
- start high in the same cycle that done is high: accepted, because the FSM is already IDLE. The new sweep begins the next cycle and the tables clear.
- out_ready is not required to be stable while out_valid is low.

## Test plan
- Reset then one start with out_ready=1 → expected symbols, each as idx=sym:
  - 0=01, 1=00, 2=10, 4=00, 40=01, 80=10;
  - out_last only at idx 80;
  - done at start+82.
- Full sweep → cnt_one=4, cnt_zero=32, cnt_x=45. table_val has bits set exactly at idx 0, 10, 30, 40. Every one of the 81 entries matches an independent bench model.
- Random out_ready backpressure at about 50% → same symbol sequence as the previous test. Held beats do not change while stalled. No index is skipped or duplicated.
- start pulsed at idx 20 mid-sweep → ignored; idx 21 follows and the totals are unchanged.
- rst_n low at idx 50 → all outputs return to reset values asynchronously and no done appears. A new start reproduces the full sweep from idx 0.
- start asserted in the done cycle → back-to-back sweep with tables cleared. The second sweep's counts equal the first.
